nw_job_arbiter: RTL and testbench

//  Shares one needwun alignment engine (10x10 chars) between NREQ requesters.

---
 rtl/nw_job_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_nw_job_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nw_job_arbiter.sv
// nw_job_arbiter
// Round-robin front end that shares a single needwun alignment engine
// (10x10 characters) between NREQ requesters. One job is in flight at a
// time: the granted job's sequences are latched and presented to the engine,
// the engine is started with a one-cycle pulse, and its done pulse is awaited
// under a cycle timeout. The result (or a timeout error) is returned on a
// shared response channel tagged with the requester index.
module nw_job_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023,
    parameter int IDW     = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*80-1:0]   req_seqa,
    input  logic [NREQ*80-1:0]   req_seqb,
    output logic                 eng_start,
    output logic [79:0]          eng_seqa,
    output logic [79:0]          eng_seqb,
    input  logic                 eng_done,
    input  logic [159:0]         eng_aliga,
    input  logic [159:0]         eng_aligb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err,
    output logic [159:0]         rsp_aliga,
    output logic [159:0]         rsp_aligb,
    output logic                 busy,
    output logic [15:0]          job_count,
    output logic [15:0]          err_count
);

    localparam int SEQ_W  = 80;
    localparam int ALIG_W = 160;
    // Timer only has to reach TIMEOUT-1
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_nx;
    logic [IDW-1:0]      rr_last;
    logic [NREQ-1:0]     pick;
    logic [IDW-1:0]      pick_idx;
    logic [SEQ_W-1:0]    sel_seqa;
    logic [SEQ_W-1:0]    sel_seqb;
    logic                grant;
    logic [TW-1:0]       tmr;
    logic                timeout_hit;

    // Round-robin pick: the valid requester closest after 'last' (cyclically)
    // wins. Distance 0 is last+1, distance NREQ-1 is last itself.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v,
                                                input logic [IDW-1:0]  last);
        logic [NREQ-1:0] g;
        int              best;
        int              d;
        g    = '0;
        best = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            d = (j + NREQ - 1 - int'(last)) % NREQ;
            if (v[j] && (d < best)) begin
                best = d;
                g    = '0;
                g[j] = 1'b1;
            end
        end
        return g;
    endfunction

    // Arbitration among current requests
    always_comb begin
        pick = rr_pick(req_valid, rr_last);
    end

    // Index and sequences of the requester currently being granted
    always_comb begin
        pick_idx = '0;
        sel_seqa = '0;
        sel_seqb = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (req_ready[j]) begin
                pick_idx = IDW'(j);
                sel_seqa = req_seqa[j*SEQ_W +: SEQ_W];
                sel_seqb = req_seqb[j*SEQ_W +: SEQ_W];
            end
        end
    end

    assign timeout_hit = (tmr == TW'(TIMEOUT - 1));

    // Next-state and state-decoded outputs; a grant is only offered in IDLE
    // and never while reset is asserted
    always_comb begin
        state_nx  = state_q;
        req_ready = '0;
        grant     = 1'b0;
        eng_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (rstn) begin
                    req_ready = pick;
                    grant     = |pick;
                end
                if (grant) begin
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                eng_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (eng_done || timeout_hit) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Latch the granted job; engine inputs stay stable until the next grant
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_last  <= IDW'(NREQ - 1);
            rsp_id   <= '0;
            eng_seqa <= '0;
            eng_seqb <= '0;
        end else if (grant) begin
            rr_last  <= pick_idx;
            rsp_id   <= pick_idx;
            eng_seqa <= sel_seqa;
            eng_seqb <= sel_seqb;
        end
    end

    // Cycles elapsed since the start pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmr <= '0;
        end else if (state_q == LAUNCH) begin
            tmr <= '0;
        end else if (state_q == WAIT) begin
            tmr <= tmr + 1'b1;
        end
    end

    // Capture the engine result or flag a timeout; done wins a tie.
    // Done pulses outside WAIT are ignored entirely.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_err   <= 1'b0;
            rsp_aliga <= '0;
            rsp_aligb <= '0;
            job_count <= '0;
            err_count <= '0;
        end else if (state_q == WAIT) begin
            if (eng_done) begin
                rsp_err   <= 1'b0;
                rsp_aliga <= eng_aliga;
                rsp_aligb <= eng_aligb;
                job_count <= job_count + 16'd1;
            end else if (timeout_hit) begin
                rsp_err   <= 1'b1;
                rsp_aliga <= {ALIG_W{1'b0}};
                rsp_aligb <= {ALIG_W{1'b0}};
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nw_job_arbiter.sv
// Testbench for nw_job_arbiter: directed jobs against a simple engine stub
// that returns each sequence reversed and padded with '_' after a
// programmable delay. Expected grants and responses go into queues; a
// monitor on the falling edge pops and compares them.
module tb_nw_job_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 16;
    localparam int IDW  = 3;

    logic                clk;
    logic                rstn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*80-1:0]  req_seqa;
    logic [NREQ*80-1:0]  req_seqb;
    logic                eng_start;
    logic [79:0]         eng_seqa;
    logic [79:0]         eng_seqb;
    logic                eng_done;
    logic [159:0]        eng_aliga;
    logic [159:0]        eng_aligb;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_err;
    logic [159:0]        rsp_aliga;
    logic [159:0]        rsp_aligb;
    logic                busy;
    logic [15:0]         job_count;
    logic [15:0]         err_count;

    nw_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO), .IDW(IDW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_seqa(req_seqa), .req_seqb(req_seqb),
        .eng_start(eng_start), .eng_seqa(eng_seqa), .eng_seqb(eng_seqb),
        .eng_done(eng_done), .eng_aliga(eng_aliga), .eng_aligb(eng_aligb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .rsp_aliga(rsp_aliga), .rsp_aligb(rsp_aligb),
        .busy(busy), .job_count(job_count), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]   id;
        logic         err;
        logic [159:0] a;
        logic [159:0] b;
        logic [15:0]  jc;
        logic [15:0]  ec;
        int           lat;
    } rsp_t;

    rsp_t exp_q[$];
    int   exp_g[$];

    // Owned by the stimulus process
    int   eng_delay = 3;
    logic late_done = 1'b0;
    int   tmo_cnt   = 0;
    bit   fin_req   = 1'b0;

    // Owned by the monitor process
    int   pass_cnt  = 0;
    int   chk_cnt   = 0;
    int   gnt_cnt   = 0;
    int   acc_cnt   = 0;
    bit   mon_done  = 1'b0;

    // Engine stub: done 'eng_delay' cycles after the start cycle (0 = never)
    logic        stub_done;
    logic [79:0] st_a;
    logic [79:0] st_b;
    int          rem;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stub_done <= 1'b0;
            rem       <= 0;
            st_a      <= '0;
            st_b      <= '0;
        end else begin
            stub_done <= 1'b0;
            if (eng_start) begin
                st_a      <= eng_seqa;
                st_b      <= eng_seqb;
                stub_done <= (eng_delay == 1);
                rem       <= (eng_delay > 1) ? eng_delay - 1 : 0;
            end else if (rem > 0) begin
                rem       <= rem - 1;
                stub_done <= (rem == 1);
            end
        end
    end

    function automatic logic [159:0] eng_out(input logic [79:0] s);
        logic [159:0] v;
        for (int i = 0; i < 20; i++)
            v[8*i +: 8] = (i < 10) ? s[8*(9-i) +: 8] : 8'h5F;
        return v;
    endfunction

    assign eng_done  = stub_done | late_done;
    assign eng_aliga = stub_done ? eng_out(st_a) : {20{8'hA5}};
    assign eng_aligb = stub_done ? eng_out(st_b) : {20{8'hA5}};

    // Char i of the string at bits [8i+7:8i]
    function automatic logic [159:0] pk(input string s);
        logic [159:0] v;
        v = '0;
        for (int i = 0; i < s.len() && i < 20; i++) v[8*i +: 8] = s[i];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    // Monitor / scoreboard
    initial begin
        int           cyc;
        int           st_cyc;
        int           tmo_seen;
        bit           prev_hs;
        bit           prev_rv;
        bit           stall;
        bit           hs;
        bit           hold_ok;
        logic [2:0]   h_id;
        logic         h_err;
        logic [159:0] h_a;
        logic [159:0] h_b;
        logic [1:0]   eg;
        rsp_t         e;
        cyc = 0; st_cyc = 0; tmo_seen = 0;
        prev_hs = 0; prev_rv = 0; stall = 0;
        h_id = '0; h_err = 1'b0; h_a = '0; h_b = '0;
        forever begin
            @(negedge clk);
            cyc++;
            while (tmo_seen < tmo_cnt) begin
                chk_cnt++;
                tmo_seen++;
            end
            if (!rstn) begin
                chk("reset_outputs_zero",
                    160'(|{req_ready, eng_start, eng_seqa, eng_seqb, rsp_valid, rsp_id,
                           rsp_err, rsp_aliga, rsp_aligb, busy, job_count, err_count}), 160'(0));
                prev_hs = 0; prev_rv = 0; stall = 0;
            end else begin
                hs = |(req_valid & req_ready);
                if (hs) begin
                    if (exp_g.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL grant_unexpected: got req_ready %b, required no grant", req_ready);
                    end else begin
                        eg = 2'b01 << exp_g.pop_front();
                        chk("grant_onehot", 160'(req_ready), 160'(eg));
                    end
                    gnt_cnt++;
                end
                if (eng_start || prev_hs)
                    chk("start_after_grant", 160'(eng_start), 160'(prev_hs));
                if (rsp_valid && !prev_rv && exp_q.size() > 0)
                    chk("start_to_rsp_latency", 160'(cyc - st_cyc), 160'(exp_q[0].lat));
                if (eng_start) st_cyc = cyc;
                if (stall) begin
                    hold_ok = rsp_valid && (rsp_id == h_id) && (rsp_err == h_err) &&
                              (rsp_aliga == h_a) && (rsp_aligb == h_b) &&
                              (req_ready == '0) && !eng_start;
                    chk("stall_hold", 160'(hold_ok), 160'(1));
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL rsp_unexpected: got id %0d, required no response", rsp_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 160'(rsp_id), 160'(e.id));
                        chk("rsp_err", 160'(rsp_err), 160'(e.err));
                        chk("rsp_aliga", rsp_aliga, e.a);
                        chk("rsp_aligb", rsp_aligb, e.b);
                        chk("job_count", 160'(job_count), 160'(e.jc));
                        chk("err_count", 160'(err_count), 160'(e.ec));
                    end
                    acc_cnt++;
                end
                stall = rsp_valid && !rsp_ready;
                h_id = rsp_id; h_err = rsp_err; h_a = rsp_aliga; h_b = rsp_aligb;
                prev_hs = hs;
                prev_rv = rsp_valid;
            end
            if (fin_req && !mon_done) begin
                chk("rsp_queue_drained", 160'(exp_q.size()), 160'(0));
                chk("grant_queue_drained", 160'(exp_g.size()), 160'(0));
                mon_done = 1'b1;
            end
        end
    end

    task automatic set_seq(input int r, input string a, input string b);
        logic [159:0] t;
        t = pk(a);
        req_seqa[r*80 +: 80] = t[79:0];
        t = pk(b);
        req_seqb[r*80 +: 80] = t[79:0];
    endtask

    task automatic push_rsp(input int id, input logic err, input string a, input string b,
                            input int jc, input int ec, input int lat);
        rsp_t e;
        e.id  = 3'(id);
        e.err = err;
        e.a   = pk(a);
        e.b   = pk(b);
        e.jc  = 16'(jc);
        e.ec  = 16'(ec);
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Hold req_valid until the monitor has seen the grant count reach target
    task automatic run_job(input logic [1:0] v, input int target);
        int n;
        @(posedge clk); #1;
        req_valid = v;
        n = 0;
        while (gnt_cnt < target && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (gnt_cnt < target) begin
            $display("FAIL wait_grant: got %0d grants, required %0d", gnt_cnt, target);
            tmo_cnt++;
        end
        req_valid = '0;
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (acc_cnt < target) begin
            $display("FAIL wait_response: got %0d responses, required %0d", acc_cnt, target);
            tmo_cnt++;
        end
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Stimulus
    initial begin
        int n;
        rstn      = 1'b1;
        req_valid = '0;
        req_seqa  = '0;
        req_seqb  = '0;
        rsp_ready = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Single job from requester 0
        eng_delay = 3;
        set_seq(0, "ACGTACGTAC", "ACGTACGTAC");
        exp_g.push_back(0);
        push_rsp(0, 1'b0, "CATGCATGCA__________", "CATGCATGCA__________", 1, 0, 4);
        run_job(2'b01, 1);
        wait_acc(1);

        // Both requesting for four jobs: alternate starting with 0
        pulse_reset(2);
        set_seq(0, "GATTACAGAT", "TTGGCCAATT");
        set_seq(1, "CCCCAAAAGG", "ACACACACAC");
        for (int k = 0; k < 4; k++) begin
            exp_g.push_back(k % 2);
            if (k % 2 == 0)
                push_rsp(0, 1'b0, "TAGACATTAG__________", "TTAACCGGTT__________", k + 1, 0, 4);
            else
                push_rsp(1, 1'b0, "GGAAAACCCC__________", "CACACACACA__________", k + 1, 0, 4);
        end
        run_job(2'b11, 5);
        wait_acc(5);

        // Response backpressure for 50 cycles with both requesters pending
        rsp_ready = 1'b0;
        set_seq(0, "AAAAACCCCC", "GGGGGTTTTT");
        exp_g.push_back(0);
        push_rsp(0, 1'b0, "CCCCCAAAAA__________", "TTTTTGGGGG__________", 5, 0, 4);
        run_job(2'b01, 6);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid) begin
            $display("FAIL wait_rsp_valid: got 0, required 1");
            tmo_cnt++;
        end
        req_valid = 2'b11;
        repeat (50) @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_acc(6);

        // Engine never finishes: timeout error, then a late done in IDLE
        eng_delay = 0;
        set_seq(1, "TGCATGCATG", "CGCGCGCGCG");
        exp_g.push_back(1);
        push_rsp(1, 1'b1, "", "", 5, 1, TMO + 1);
        run_job(2'b10, 7);
        wait_acc(7);
        @(posedge clk); #1 late_done = 1'b1;
        @(posedge clk); #1 late_done = 1'b0;

        // Done arrives in the same cycle the timeout expires: done wins
        eng_delay = TMO;
        set_seq(0, "CAGTCAGTCA", "ACGTTGCAAC");
        exp_g.push_back(0);
        push_rsp(0, 1'b0, "ACTGACTGAC__________", "CAACGTTGCA__________", 6, 1, TMO + 1);
        run_job(2'b01, 8);
        wait_acc(8);

        // Reset while waiting on the engine; afterwards requester 0 wins
        eng_delay = 0;
        exp_g.push_back(1);
        run_job(2'b10, 9);
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        eng_delay = 2;
        set_seq(0, "TTTTTGGGGG", "CCCCCAAAAA");
        exp_g.push_back(0);
        push_rsp(0, 1'b0, "GGGGGTTTTT__________", "AAAAACCCCC__________", 1, 0, 3);
        run_job(2'b11, 10);
        wait_acc(9);

        repeat (3) @(posedge clk);
        fin_req = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
